// File: rtl/baud_cfg_pkg.sv
// Shared definitions for the baud configuration sequencer: FSM encoding,
// divider register widths, reset defaults and the 50 MHz preset table.
package baud_cfg_pkg;

  localparam int FREQ_W  = 12;
  localparam int LIMIT_W = 16;
  localparam int IDX_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLD    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_WAIT_CE = 3'd4,
    ST_DONE    = 3'd5
  } cfg_state_t;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [LIMIT_W-1:0] limit;
  } baud_pair_t;

  localparam logic [FREQ_W-1:0]  RST_FREQ  = 12'd1152;
  localparam logic [LIMIT_W-1:0] RST_LIMIT = 16'd14473;

  // Reserved slots mirror preset 0 so a build that enables them still gets a sane rate.
  function automatic baud_pair_t preset_lookup(input logic [IDX_W-1:0] idx);
    baud_pair_t p;
    case (idx)
      3'd0:    p = '{freq: RST_FREQ,  limit: RST_LIMIT};
      3'd1:    p = '{freq: 12'd96,    limit: 16'd15529};
      3'd2:    p = '{freq: 12'd192,   limit: 16'd15433};
      3'd3:    p = '{freq: 12'd384,   limit: 16'd15241};
      3'd4:    p = '{freq: 12'd576,   limit: 16'd15049};
      default: p = '{freq: RST_FREQ,  limit: RST_LIMIT};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/baud_preset_rom.sv
// Combinational preset index -> {baud_freq, baud_limit} lookup.
module baud_preset_rom
  import baud_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] i_idx,
  output baud_pair_t       o_pair
);

  always_comb begin
    o_pair = preset_lookup(i_idx);
  end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Runtime baud-rate switch sequencer: hold UART, drain, reset divider, load, confirm tick.
// Optional drain timeout abort enabled by defining BAUD_CFG_TIMEOUT_EN.
module baud_cfg_ctrl
  import baud_cfg_pkg::*;
#(
  parameter int NUM_PRESETS   = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 65535
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cfg_req,
  input  logic               cfg_mode,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [FREQ_W-1:0]  cfg_freq,
  input  logic [LIMIT_W-1:0] cfg_limit,
  output logic               cfg_ack,
  output logic               cfg_err,
  input  logic               uart_busy,
  output logic               uart_hold,
  output logic               gen_reset,
  output logic [FREQ_W-1:0]  baud_freq,
  output logic [LIMIT_W-1:0] baud_limit,
  input  logic               ce_32,
  output logic               baud_valid
);

  localparam logic [IDX_W:0] NP_LIM   = (IDX_W+1)'(NUM_PRESETS);
  localparam int             SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  cfg_state_t           r_state;
  cfg_state_t           w_next;
  logic                 r_err;
  logic                 r_baud_valid;
  logic [FREQ_W-1:0]    r_baud_freq;
  logic [LIMIT_W-1:0]   r_baud_limit;
  logic [SETTLE_W-1:0]  r_settle_cnt;

  logic                 r_sh_mode;
  logic [IDX_W-1:0]     r_sh_idx;
  logic [FREQ_W-1:0]    r_sh_freq;
  logic [LIMIT_W-1:0]   r_sh_limit;

  logic                 w_req_ok;
  logic                 w_req_take;
  logic                 w_enter_load;
  logic                 w_drain_abort;
  logic                 w_uart_hold;
  logic                 w_gen_reset;
  logic                 w_ack;
  baud_pair_t           w_rom_pair;
  logic [FREQ_W-1:0]    w_new_freq;
  logic [LIMIT_W-1:0]   w_new_limit;

  baud_preset_rom u_rom (
    .i_idx  (r_sh_idx),
    .o_pair (w_rom_pair)
  );

  assign w_req_ok     = cfg_mode ? ((cfg_freq != '0) && (cfg_limit != '0))
                                 : ({1'b0, cfg_idx} < NP_LIM);
  assign w_req_take   = (r_state == ST_IDLE) && cfg_req;
  assign w_enter_load = (r_state == ST_HOLD) && !uart_busy;
  assign w_new_freq   = r_sh_mode ? r_sh_freq  : w_rom_pair.freq;
  assign w_new_limit  = r_sh_mode ? r_sh_limit : w_rom_pair.limit;

`ifdef BAUD_CFG_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(DRAIN_TIMEOUT - 1);
  logic [15:0] r_to_cnt;

  // Counts busy cycles spent draining; cleared whenever we are not in HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_HOLD) begin
      r_to_cnt <= '0;
    end else if (uart_busy) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  assign w_drain_abort = (r_state == ST_HOLD) && uart_busy && (r_to_cnt == TO_LAST);
`else
  localparam int unused_drain_timeout = DRAIN_TIMEOUT;
  assign w_drain_abort = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_uart_hold = 1'b0;
    w_gen_reset = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_req && w_req_ok) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_uart_hold = 1'b1;
        if (!uart_busy)         w_next = ST_LOAD;
        else if (w_drain_abort) w_next = ST_IDLE;
      end
      ST_LOAD, ST_SETTLE: begin
        w_uart_hold = 1'b1;
        w_gen_reset = 1'b1;
        if (r_settle_cnt == '0) w_next = ST_WAIT_CE;
        else                    w_next = ST_SETTLE;
      end
      ST_WAIT_CE: begin
        w_uart_hold = 1'b1;
        if (ce_32) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_ack  = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= (w_req_take && !w_req_ok) || w_drain_abort;
    end
  end

  // Shadow copy of the request; only meaningful once the FSM leaves IDLE.
  always_ff @(posedge clock) begin
    if (w_req_take) begin
      r_sh_mode  <= cfg_mode;
      r_sh_idx   <= cfg_idx;
      r_sh_freq  <= cfg_freq;
      r_sh_limit <= cfg_limit;
    end
  end

  // New pair and divider reset become visible together in the LOAD cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_baud_freq  <= RST_FREQ;
      r_baud_limit <= RST_LIMIT;
      r_baud_valid <= 1'b0;
      r_settle_cnt <= '0;
    end else begin
      if (w_enter_load) begin
        r_baud_freq  <= w_new_freq;
        r_baud_limit <= w_new_limit;
        r_settle_cnt <= SETTLE_LAST;
      end else if (w_gen_reset && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      if (w_enter_load) begin
        r_baud_valid <= 1'b0;
      end else if (ce_32 && !w_gen_reset) begin
        r_baud_valid <= 1'b1;
      end
    end
  end

  assign cfg_ack    = w_ack;
  assign cfg_err    = r_err;
  assign uart_hold  = w_uart_hold;
  assign gen_reset  = w_gen_reset;
  assign baud_freq  = r_baud_freq;
  assign baud_limit = r_baud_limit;
  assign baud_valid = r_baud_valid;

endmodule
